// File: rtl/escalonador_senha_pkg.sv
// Shared definitions for the lock's password path.
// Holds the keypad digit codes, buffer/password sizes, the keypad buffer and
// stored password types, and a helper that measures a stored password's length.
package escalonador_senha_pkg;

   localparam logic [3:0] DIG_ENTER = 4'hA;
   localparam logic [3:0] DIG_CLEAR = 4'hB;
   localparam logic [3:0] DIG_EMPTY = 4'hF;

   localparam int MAX_DIG = 12;
   localparam int BUF_DIG = 20;

   // Width of a password length (0..MAX_DIG) and of a window offset (0..BUF_DIG-1)
   localparam int LEN_W = 4;
   localparam int OFF_W = 5;

   // Stored password: digit[0] is the first one typed, unused tail padded with 0xF
   typedef logic [3:0] senha_t [MAX_DIG];

   // Keypad buffer: digits[0] is the newest key, digits[BUF_DIG-1] the oldest
   typedef struct packed {
      logic [BUF_DIG-1:0][3:0] digits;
   } senhaPac_t;

   // Number of leading non-empty digits; anything after the first 0xF is ignored
   function automatic logic [LEN_W-1:0] senhaLen(input senha_t s);
      logic [LEN_W-1:0] n;
      logic             stop;
      n    = '0;
      stop = 1'b0;
      for (int j = 0; j < MAX_DIG; j++) begin
         if (!stop && s[j] != DIG_EMPTY) begin
            n = n + 1'b1;
         end else begin
            stop = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/escalonador_senha_comparador.sv
// comparador_janela: the single shared window comparator.
// Checks whether stored password 'senha' of length 'len' sits in the snapshot
// buffer with its last digit at position off+1 (first digit at off+len).
// Ports:
//   snap  in  snapshot buffer, index 0 newest (slot 0 is never a valid digit)
//   senha in  stored password, digit[0] typed first
//   len   in  number of significant password digits
//   off   in  window offset
//   hit   out all significant digits match
module comparador_janela
   import escalonador_senha_pkg::*;
(
   input  logic [BUF_DIG-1:0][3:0] snap,
   input  senha_t                  senha,
   input  logic [LEN_W-1:0]        len,
   input  logic [OFF_W-1:0]        off,
   output logic                    hit
);

   localparam int POS_W = OFF_W + 1;

   logic [POS_W-1:0] pos;

   // Digit j of the password must equal buffer position off+len-j, because the
   // first typed digit is the oldest one and so sits deepest in the buffer.
   // An empty digit on either side never counts as a match, and a window that
   // would run past the oldest buffer slot is rejected outright.
   always_comb begin
      hit = 1'b1;
      pos = '0;
      for (int j = 0; j < MAX_DIG; j++) begin
         if (LEN_W'(j) < len) begin
            pos = {1'b0, off} + POS_W'(len) - POS_W'(j);
            if (pos > POS_W'(BUF_DIG - 1)) begin
               hit = 1'b0;
            end else if (senha[j] == DIG_EMPTY || snap[pos[OFF_W-1:0]] != senha[j]) begin
               hit = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/escalonador_senha.sv
// escalonador_senha: sequences the shared password comparator.
// On '*' the keypad buffer, stored passwords and enables are snapshotted and
// every enabled password is searched for as a contiguous run of the entered
// digits, one (password, offset) pair per cycle. The result is strobed to the
// operational FSM, consecutive failures are counted and, on reaching
// MAX_FALHAS, a lockout of LOCK_CYCLES cycles is enforced.
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   digitos_value  keypad buffer (digits[0] newest, 0xF empty)
//   digitos_valid  strobe: buffer just updated
//   senhas         stored passwords, senha_en per-password enable
//   busy           scan, result or lockout in progress
//   res_valid      one-cycle result strobe, res_ok / res_idx result
//   bloqueado      lockout active, falhas consecutive failure count
module escalonador_senha
   import escalonador_senha_pkg::*;
#(
   parameter  int N_SENHAS    = 4,
   parameter  int MAX_FALHAS  = 5,
   parameter  int LOCK_CYCLES = 30000,
   localparam int IDX_W       = (N_SENHAS > 1) ? $clog2(N_SENHAS) : 1,
   localparam int FALHA_W     = $clog2(MAX_FALHAS + 1),
   localparam int CNT_W       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
)(
   input  logic               clk,
   input  logic               rst,
   input  senhaPac_t          digitos_value,
   input  logic               digitos_valid,
   input  senha_t             senhas [N_SENHAS],
   input  logic [N_SENHAS-1:0] senha_en,
   output logic               busy,
   output logic               res_valid,
   output logic               res_ok,
   output logic [IDX_W-1:0]   res_idx,
   output logic               bloqueado,
   output logic [FALHA_W-1:0] falhas
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE, LOCK} state_t;

   state_t                  state, stateNext;
   logic [IDX_W-1:0]        pIdx, pNext;
   logic [OFF_W-1:0]        oIdx, oNext;
   logic                    resOk, resOkNext;
   logic [IDX_W-1:0]        resIdx, resIdxNext;
   logic [FALHA_W-1:0]      falhasQ, falhasNext;
   logic [CNT_W-1:0]        lockCnt, cntNext;
   logic                    capture;

   logic [BUF_DIG-1:0][3:0] snapDig;
   senha_t                  snapSenhas [N_SENHAS];
   logic [N_SENHAS-1:0]     snapEn;

   senha_t                  senhaCur;
   logic [LEN_W-1:0]        lenCur;
   logic [OFF_W-1:0]        lastOff;
   logic                    skip;
   logic                    lastP;
   logic                    hit;

   // Select the password currently under test from the snapshot and derive
   // its length, last legal offset, and whether it should be skipped (disabled
   // or too short to be a real password). A skipped password costs one cycle.
   always_comb begin
      senhaCur = snapSenhas[pIdx];
      lenCur   = senhaLen(senhaCur);
      lastOff  = OFF_W'(BUF_DIG - 1) - OFF_W'(lenCur);
      skip     = !snapEn[pIdx] || (lenCur < LEN_W'(4));
      lastP    = (pIdx == IDX_W'(N_SENHAS - 1));
   end

   comparador_janela u_comparador (
      .snap  (snapDig),
      .senha (senhaCur),
      .len   (lenCur),
      .off   (oIdx),
      .hit   (hit)
   );

   // Next-state and datapath decisions. In SCAN the first hit in
   // (password ascending, offset ascending) order ends the search; otherwise
   // the offset walks to its last legal value, then the next password starts
   // at offset 0. DONE lasts one cycle and settles the failure count; reaching
   // the failure limit enters LOCK, which counts down LOCK_CYCLES cycles.
   always_comb begin
      stateNext  = state;
      pNext      = pIdx;
      oNext      = oIdx;
      resOkNext  = resOk;
      resIdxNext = resIdx;
      falhasNext = falhasQ;
      cntNext    = lockCnt;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (digitos_valid && digitos_value.digits[0] == DIG_ENTER) begin
               capture   = 1'b1;
               pNext     = '0;
               oNext     = '0;
               stateNext = SCAN;
            end
         end
         SCAN: begin
            if (!skip && hit) begin
               resOkNext  = 1'b1;
               resIdxNext = pIdx;
               stateNext  = DONE;
            end else if (skip || oIdx == lastOff) begin
               oNext = '0;
               if (lastP) begin
                  resOkNext = 1'b0;
                  stateNext = DONE;
               end else begin
                  pNext = pIdx + 1'b1;
               end
            end else begin
               oNext = oIdx + 1'b1;
            end
         end
         DONE: begin
            if (resOk) begin
               falhasNext = '0;
               stateNext  = IDLE;
            end else begin
               if (falhasQ < FALHA_W'(MAX_FALHAS)) begin
                  falhasNext = falhasQ + 1'b1;
               end
               if (falhasQ >= FALHA_W'(MAX_FALHAS - 1)) begin
                  cntNext   = CNT_W'(LOCK_CYCLES - 1);
                  stateNext = LOCK;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         LOCK: begin
            if (lockCnt == '0) begin
               falhasNext = '0;
               stateNext  = IDLE;
            end else begin
               cntNext = lockCnt - 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Control and result registers. A reset in any state drops straight back
   // to IDLE, so an interrupted scan or lockout never produces a result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pIdx    <= '0;
         oIdx    <= '0;
         resOk   <= 1'b0;
         resIdx  <= '0;
         falhasQ <= '0;
         lockCnt <= '0;
      end else begin
         state   <= stateNext;
         pIdx    <= pNext;
         oIdx    <= oNext;
         resOk   <= resOkNext;
         resIdx  <= resIdxNext;
         falhasQ <= falhasNext;
         lockCnt <= cntNext;
      end
   end

   // Snapshot taken on the accepted '*'. The '*' itself (slot 0) is replaced
   // by an empty digit so it can never take part in a match. Keeping private
   // copies makes keypad or password edits during a scan harmless.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snapDig <= '1;
         snapEn  <= '0;
         for (int i = 0; i < N_SENHAS; i++) begin
            for (int j = 0; j < MAX_DIG; j++) begin
               snapSenhas[i][j] <= DIG_EMPTY;
            end
         end
      end else if (capture) begin
         snapDig <= {digitos_value.digits[BUF_DIG-1:1], DIG_EMPTY};
         snapEn  <= senha_en;
         for (int i = 0; i < N_SENHAS; i++) begin
            snapSenhas[i] <= senhas[i];
         end
      end
   end

   assign busy      = (state != IDLE);
   assign res_valid = (state == DONE);
   assign bloqueado = (state == LOCK);
   assign res_ok    = resOk;
   assign res_idx   = resIdx;
   assign falhas    = falhasQ;

endmodule

// File: tb/tb_escalonador_senha.sv
// Directed bench for escalonador_senha with short lockout (LOCK_CYCLES=20).
// Expected latencies are hand-derived: trigger edge T, k-th scan cycle T+k,
// result strobe one cycle after the deciding compare; a skipped password
// costs one cycle, a password of length L costs 20-L cycles when it misses.
module tb_escalonador_senha;
   import escalonador_senha_pkg::*;

   localparam int NS = 4;
   localparam int MF = 5;
   localparam int LC = 20;

   logic          clk;
   logic          rst;
   senhaPac_t     digitos_value;
   logic          digitos_valid;
   senha_t        senhas [NS];
   logic [NS-1:0] senha_en;
   logic          busy;
   logic          res_valid;
   logic          res_ok;
   logic [1:0]    res_idx;
   logic          bloqueado;
   logic [2:0]    falhas;

   senhaPac_t     keyBuf;
   int            checks = 0;
   int            errors = 0;
   int            resPulses = 0;
   int            lat;
   int            pulsesBefore;
   int            lockCycles;

   escalonador_senha #(
      .N_SENHAS    (NS),
      .MAX_FALHAS  (MF),
      .LOCK_CYCLES (LC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .digitos_value (digitos_value),
      .digitos_valid (digitos_valid),
      .senhas        (senhas),
      .senha_en      (senha_en),
      .busy          (busy),
      .res_valid     (res_valid),
      .res_ok        (res_ok),
      .res_idx       (res_idx),
      .bloqueado     (bloqueado),
      .falhas        (falhas)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count result strobes, sampled mid-cycle, to catch spurious results
   always @(negedge clk) begin
      if (res_valid === 1'b1) resPulses++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Press one key: shift it into the buffer and strobe for one clock edge
   task automatic applyStimulus(input logic [3:0] d);
      @(negedge clk);
      keyBuf.digits = {keyBuf.digits[BUF_DIG-2:0], d};
      digitos_value = keyBuf;
      digitos_valid = 1'b1;
      @(negedge clk);
      digitos_valid = 1'b0;
   endtask

   task automatic typeDigits(input logic [47:0] seq, input int n);
      for (int i = 0; i < n; i++) applyStimulus(seq[47-4*i -: 4]);
   endtask

   task automatic clearBuffer();
      keyBuf.digits = '1;
      digitos_value = keyBuf;
   endtask

   task automatic setSenha(input int idx, input logic [47:0] v);
      for (int j = 0; j < MAX_DIG; j++) senhas[idx][j] = v[47-4*j -: 4];
   endtask

   // Wait (bounded) for the result strobe; latOut is the cycle index after T
   task automatic waitResult(input int startLat, output int latOut);
      latOut = startLat;
      while (res_valid !== 1'b1 && latOut < 60) begin
         @(negedge clk);
         latOut++;
      end
      checkOutput("resultSeen", {31'd0, res_valid}, 32'd1);
   endtask

   // Full attempt: clear, type two digit groups, press '*', check result
   task automatic attempt(input logic [47:0] seqA, input int nA, input logic [47:0] seqB, input int nB,
                          input int expLat, input logic expOk, input logic [1:0] expIdx,
                          input logic [2:0] expFalhas, input string tag);
      clearBuffer();
      typeDigits(seqA, nA);
      typeDigits(seqB, nB);
      applyStimulus(DIG_ENTER);
      waitResult(1, lat);
      checkOutput({tag, "_lat"}, lat, expLat);
      checkOutput({tag, "_ok"}, {31'd0, res_ok}, {31'd0, expOk});
      if (expOk) checkOutput({tag, "_idx"}, {30'd0, res_idx}, {30'd0, expIdx});
      @(negedge clk);
      checkOutput({tag, "_falhas"}, {29'd0, falhas}, {29'd0, expFalhas});
   endtask

   initial begin
      rst           = 1'b0;
      digitos_valid = 1'b0;
      keyBuf.digits = '1;
      digitos_value = keyBuf;
      for (int i = 0; i < NS; i++) setSenha(i, 48'hFFFFFFFFFFFF);
      setSenha(0, 48'h12345678FFFF);
      senha_en = 4'b0001;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("rst_ok", {31'd0, res_ok}, 32'd0);
      checkOutput("rst_idx", {30'd0, res_idx}, 32'd0);
      checkOutput("rst_bloq", {31'd0, bloqueado}, 32'd0);
      checkOutput("rst_falhas", {29'd0, falhas}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Password right before '*': hit on the first compare
      attempt(48'h90909090909F, 11, 48'h12345678FFFF, 8, 2, 1'b1, 2'd0, 3'd0, "first");
      // Password followed by 11 digits: hit at the last offset
      attempt(48'h12345678FFFF, 8, 48'h09090909090F, 11, 13, 1'b1, 2'd0, 3'd0, "lastOff");
      // One digit more: first password digit shifted out, full miss
      attempt(48'h12345678FFFF, 8, 48'h090909090909, 12, 16, 1'b0, 2'd0, 3'd1, "shifted");

      // Only password 2 enabled
      setSenha(2, 48'h9876FFFFFFFF);
      senha_en = 4'b0100;
      attempt(48'h9876FFFFFFFF, 4, 48'h0, 0, 4, 1'b1, 2'd2, 3'd0, "idx2");
      attempt(48'h1111FFFFFFFF, 4, 48'h0, 0, 20, 1'b0, 2'd0, 3'd1, "wrong1");
      attempt(48'h1111FFFFFFFF, 4, 48'h0, 0, 20, 1'b0, 2'd0, 3'd2, "wrong2");
      attempt(48'h1111FFFFFFFF, 4, 48'h0, 0, 20, 1'b0, 2'd0, 3'd3, "wrong3");
      attempt(48'h9876FFFFFFFF, 4, 48'h0, 0, 4, 1'b1, 2'd2, 3'd0, "recover");

      // Five failures lead to lockout
      attempt(48'h1111FFFFFFFF, 4, 48'h0, 0, 20, 1'b0, 2'd0, 3'd1, "lk1");
      attempt(48'h1111FFFFFFFF, 4, 48'h0, 0, 20, 1'b0, 2'd0, 3'd2, "lk2");
      attempt(48'h1111FFFFFFFF, 4, 48'h0, 0, 20, 1'b0, 2'd0, 3'd3, "lk3");
      attempt(48'h1111FFFFFFFF, 4, 48'h0, 0, 20, 1'b0, 2'd0, 3'd4, "lk4");
      clearBuffer();
      typeDigits(48'h1111FFFFFFFF, 4);
      applyStimulus(DIG_ENTER);
      waitResult(1, lat);
      checkOutput("lk5_lat", lat, 32'd20);
      checkOutput("lk5_ok", {31'd0, res_ok}, 32'd0);
      @(negedge clk);
      checkOutput("lock_bloq", {31'd0, bloqueado}, 32'd1);
      checkOutput("lock_busy", {31'd0, busy}, 32'd1);
      checkOutput("lock_falhas", {29'd0, falhas}, 32'd5);
      lockCycles   = 1;
      pulsesBefore = resPulses;
      clearBuffer();
      typeDigits(48'h9876FFFFFFFF, 4);
      applyStimulus(DIG_ENTER);
      lockCycles += 10;
      checkOutput("lock_stillBloq", {31'd0, bloqueado}, 32'd1);
      while (bloqueado === 1'b1 && lockCycles < 100) begin
         @(negedge clk);
         if (bloqueado === 1'b1) lockCycles++;
      end
      checkOutput("lock_len", lockCycles, LC);
      checkOutput("unlock_falhas", {29'd0, falhas}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("unlock_busy", {31'd0, busy}, 32'd0);
      checkOutput("lock_noResult", resPulses - pulsesBefore, 32'd0);
      attempt(48'h9876FFFFFFFF, 4, 48'h0, 0, 4, 1'b1, 2'd2, 3'd0, "afterLock");

      // Reset in the middle of a scan
      attempt(48'h1111FFFFFFFF, 4, 48'h0, 0, 20, 1'b0, 2'd0, 3'd1, "preRst");
      clearBuffer();
      typeDigits(48'h1111FFFFFFFF, 4);
      applyStimulus(DIG_ENTER);
      repeat (4) @(negedge clk);
      pulsesBefore = resPulses;
      rst = 1'b0;
      #1;
      checkOutput("midRst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midRst_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("midRst_falhas", {29'd0, falhas}, 32'd0);
      checkOutput("midRst_idx", {30'd0, res_idx}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (25) @(negedge clk);
      checkOutput("midRst_noResult", resPulses - pulsesBefore, 32'd0);

      // Clear key and plain digits do not start a scan
      clearBuffer();
      pulsesBefore = resPulses;
      applyStimulus(DIG_CLEAR);
      checkOutput("clearKey_busy", {31'd0, busy}, 32'd0);
      applyStimulus(4'h5);
      checkOutput("digit_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("idle_noResult", resPulses - pulsesBefore, 32'd0);

      // Retrigger while busy is ignored; password edits mid-scan are not seen
      clearBuffer();
      typeDigits(48'h1111FFFFFFFF, 4);
      applyStimulus(DIG_ENTER);
      pulsesBefore = resPulses;
      applyStimulus(DIG_ENTER);
      setSenha(2, 48'h1111FFFFFFFF);
      senha_en = 4'b1111;
      waitResult(3, lat);
      checkOutput("snap_lat", lat, 32'd20);
      checkOutput("snap_ok", {31'd0, res_ok}, 32'd0);
      @(negedge clk);
      checkOutput("snap_falhas", {29'd0, falhas}, 32'd1);
      repeat (30) @(negedge clk);
      checkOutput("retrig_pulses", resPulses - pulsesBefore, 32'd1);
      checkOutput("retrig_busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
